// File: rtl/axi_slv_port_router_pkg.sv
// Shared types for the AXI slave-port router: channel structs, bundles, rules and decode helper.
package axi_slv_port_router_pkg;

    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned IdWidth      = 4;
    localparam int unsigned RuleIdxWidth = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [IdWidth-1:0]   id_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [5:0] atop;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

    typedef struct packed {
        logic [RuleIdxWidth-1:0] idx;
        addr_t                   start_addr;
        addr_t                   end_addr;
    } rule_t;

    // Half-open interval match: start_addr <= addr < end_addr.
    function automatic logic addr_decode(input rule_t rule, input addr_t addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/axi_slv_port_router_err_slv.sv
// Decode-error responder: sinks writes and answers every burst with DECERR.
module axi_slv_port_router_err_slv
    import axi_slv_port_router_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  req_i,
    output resp_t resp_o
);

    localparam int unsigned IdDepth = 4;
    localparam logic [0:0] RdIdle = 1'b0;
    localparam logic [0:0] RdBusy = 1'b1;

    id_t        id_fifo_q [IdDepth];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] id_cnt_q;
    logic       b_valid_q;
    id_t        b_id_q;
    logic [0:0] rd_state_q;
    id_t        r_id_q;
    logic [7:0] r_len_q, r_cnt_q;

    logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs;
    logic unused_req;

    assign unused_req = ^req_i;

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = (id_cnt_q != 3'd4);
        // W stalls while a B is pending so only one B is ever in flight.
        resp_o.w_ready  = (id_cnt_q != 3'd0) && !b_valid_q;
        resp_o.b.id     = b_id_q;
        resp_o.b.resp   = RESP_DECERR;
        resp_o.b_valid  = b_valid_q;
        resp_o.ar_ready = (rd_state_q == RdIdle);
        resp_o.r.id     = r_id_q;
        resp_o.r.data   = '0;
        resp_o.r.resp   = RESP_DECERR;
        resp_o.r.last   = (r_cnt_q == r_len_q);
        resp_o.r_valid  = (rd_state_q == RdBusy);
    end

    assign aw_hs     = req_i.aw_valid && resp_o.aw_ready;
    assign w_last_hs = req_i.w_valid && resp_o.w_ready && req_i.w.last;
    assign b_hs      = b_valid_q && req_i.b_ready;
    assign ar_hs     = req_i.ar_valid && resp_o.ar_ready;
    assign r_hs      = resp_o.r_valid && req_i.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            id_cnt_q  <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            for (int unsigned i = 0; i < IdDepth; i++) id_fifo_q[i] <= '0;
        end else begin
            if (aw_hs) begin
                id_fifo_q[wr_ptr_q] <= req_i.aw.id;
                wr_ptr_q            <= wr_ptr_q + 2'd1;
            end
            if (w_last_hs) begin
                b_id_q    <= id_fifo_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 2'd1;
                b_valid_q <= 1'b1;
            end else if (b_hs) begin
                b_valid_q <= 1'b0;
            end
            if (aw_hs && !w_last_hs) begin
                id_cnt_q <= id_cnt_q + 3'd1;
            end else if (!aw_hs && w_last_hs) begin
                id_cnt_q <= id_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= RdIdle;
            r_id_q     <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RdIdle: begin
                    if (ar_hs) begin
                        r_id_q     <= req_i.ar.id;
                        r_len_q    <= req_i.ar.len;
                        r_cnt_q    <= '0;
                        rd_state_q <= RdBusy;
                    end
                end
                RdBusy: begin
                    if (r_hs) begin
                        if (resp_o.r.last) rd_state_q <= RdIdle;
                        else               r_cnt_q    <= r_cnt_q + 8'd1;
                    end
                end
                default: rd_state_q <= RdIdle;
            endcase
        end
    end

endmodule

// File: rtl/axi_slv_port_router.sv
// AXI4 slave-port front end: decodes AW/AR, routes to one target per direction, keeps W order.
module axi_slv_port_router
    import axi_slv_port_router_pkg::*;
#(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned NoRules    = 4,
    parameter int unsigned MaxTrans   = 8,
    localparam int unsigned PortWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  req_t                 slv_req_i,
    output resp_t                slv_resp_o,
    output req_t                 mst_reqs_o [NoMstPorts],
    input  resp_t                mst_resps_i [NoMstPorts],
    input  rule_t                addr_map_i [NoRules],
    input  logic                 en_default_mst_port_i,
    input  logic [PortWidth-1:0] default_mst_port_i
);

    localparam int unsigned SelWidth = $clog2(NoMstPorts + 1);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    typedef logic [SelWidth-1:0] sel_t;
    typedef logic [CntWidth-1:0] cnt_t;
    typedef logic [PtrWidth-1:0] ptr_t;

    localparam sel_t ErrIdx  = sel_t'(NoMstPorts);
    localparam cnt_t MaxCnt  = cnt_t'(MaxTrans);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam ptr_t PtrLast = ptr_t'(MaxTrans - 1);
    localparam ptr_t PtrOne  = ptr_t'(1);

    function automatic sel_t decode(input addr_t addr, input rule_t map [NoRules],
                                    input logic en_def, input logic [PortWidth-1:0] def_port);
        sel_t tgt;
        logic hit;
        tgt = ErrIdx;
        hit = 1'b0;
        for (int unsigned i = 0; i < NoRules; i++) begin
            if (addr_decode(map[i], addr)) begin
                hit = 1'b1;
                tgt = (32'(map[i].idx) < NoMstPorts) ? sel_t'(map[i].idx) : ErrIdx;
            end
        end
        if (!hit && en_def) tgt = sel_t'(def_port);
        return tgt;
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrOne;
    endfunction

    logic act;
    sel_t aw_tgt, aw_lock_tgt_q, last_aw_tgt_q;
    sel_t ar_tgt, ar_lock_tgt_q, last_ar_tgt_q;
    logic aw_lock_q, ar_lock_q;
    logic aw_go, ar_go, aw_hs, ar_hs, b_hs, r_last_hs, w_last_hs;
    cnt_t w_out_q, w_out_d, r_out_q, r_out_d;

    sel_t w_fifo_q [MaxTrans];
    ptr_t w_wr_ptr_q, w_rd_ptr_q;
    cnt_t w_cnt_q;
    logic w_nonempty, w_full;
    sel_t w_head;

    req_t  err_req;
    resp_t err_resp;

    assign act        = !rst_i;
    assign w_nonempty = (w_cnt_q != '0);
    assign w_full     = (w_cnt_q == MaxCnt);
    assign w_head     = w_fifo_q[w_rd_ptr_q];

    // The target is frozen once a valid has been presented, so a changing address map cannot
    // retarget a pending request.
    assign aw_tgt = aw_lock_q ? aw_lock_tgt_q
        : decode(slv_req_i.aw.addr, addr_map_i, en_default_mst_port_i, default_mst_port_i);
    assign ar_tgt = ar_lock_q ? ar_lock_tgt_q
        : decode(slv_req_i.ar.addr, addr_map_i, en_default_mst_port_i, default_mst_port_i);

    assign aw_go = act && slv_req_i.aw_valid && !w_full && (w_out_q != MaxCnt)
                   && !((w_out_q != '0) && (aw_tgt != last_aw_tgt_q));
    assign ar_go = act && slv_req_i.ar_valid && (r_out_q != MaxCnt)
                   && !((r_out_q != '0) && (ar_tgt != last_ar_tgt_q));

    always_comb begin
        for (int unsigned j = 0; j < NoMstPorts; j++) begin
            mst_reqs_o[j]          = slv_req_i;
            mst_reqs_o[j].aw_valid = aw_go && (aw_tgt == sel_t'(j));
            mst_reqs_o[j].w_valid  = act && slv_req_i.w_valid && w_nonempty
                                     && (w_head == sel_t'(j));
            mst_reqs_o[j].b_ready  = act && slv_req_i.b_ready && (last_aw_tgt_q == sel_t'(j));
            mst_reqs_o[j].ar_valid = ar_go && (ar_tgt == sel_t'(j));
            mst_reqs_o[j].r_ready  = act && slv_req_i.r_ready && (last_ar_tgt_q == sel_t'(j));
        end
        err_req          = slv_req_i;
        err_req.aw_valid = aw_go && (aw_tgt == ErrIdx);
        err_req.w_valid  = act && slv_req_i.w_valid && w_nonempty && (w_head == ErrIdx);
        err_req.b_ready  = act && slv_req_i.b_ready && (last_aw_tgt_q == ErrIdx);
        err_req.ar_valid = ar_go && (ar_tgt == ErrIdx);
        err_req.r_ready  = act && slv_req_i.r_ready && (last_ar_tgt_q == ErrIdx);
    end

    always_comb begin
        slv_resp_o = '0;
        for (int unsigned j = 0; j < NoMstPorts; j++) begin
            if (aw_tgt == sel_t'(j)) slv_resp_o.aw_ready = mst_resps_i[j].aw_ready;
            if (ar_tgt == sel_t'(j)) slv_resp_o.ar_ready = mst_resps_i[j].ar_ready;
            if (w_head == sel_t'(j)) slv_resp_o.w_ready  = mst_resps_i[j].w_ready;
            if (last_aw_tgt_q == sel_t'(j)) begin
                slv_resp_o.b       = mst_resps_i[j].b;
                slv_resp_o.b_valid = mst_resps_i[j].b_valid;
            end
            if (last_ar_tgt_q == sel_t'(j)) begin
                slv_resp_o.r       = mst_resps_i[j].r;
                slv_resp_o.r_valid = mst_resps_i[j].r_valid;
            end
        end
        if (aw_tgt == ErrIdx) slv_resp_o.aw_ready = err_resp.aw_ready;
        if (ar_tgt == ErrIdx) slv_resp_o.ar_ready = err_resp.ar_ready;
        if (w_head == ErrIdx) slv_resp_o.w_ready  = err_resp.w_ready;
        if (last_aw_tgt_q == ErrIdx) begin
            slv_resp_o.b       = err_resp.b;
            slv_resp_o.b_valid = err_resp.b_valid;
        end
        if (last_ar_tgt_q == ErrIdx) begin
            slv_resp_o.r       = err_resp.r;
            slv_resp_o.r_valid = err_resp.r_valid;
        end
        slv_resp_o.aw_ready = slv_resp_o.aw_ready && aw_go;
        slv_resp_o.ar_ready = slv_resp_o.ar_ready && ar_go;
        slv_resp_o.w_ready  = slv_resp_o.w_ready && w_nonempty && act;
        slv_resp_o.b_valid  = slv_resp_o.b_valid && act;
        slv_resp_o.r_valid  = slv_resp_o.r_valid && act;
    end

    assign aw_hs     = slv_resp_o.aw_ready;
    assign ar_hs     = slv_resp_o.ar_ready;
    assign w_last_hs = slv_resp_o.w_ready && slv_req_i.w_valid && slv_req_i.w.last;
    assign b_hs      = slv_resp_o.b_valid && slv_req_i.b_ready;
    assign r_last_hs = slv_resp_o.r_valid && slv_req_i.r_ready && slv_resp_o.r.last;

    always_comb begin
        w_out_d = w_out_q;
        r_out_d = r_out_q;
        if (aw_hs && !b_hs)      w_out_d = w_out_q + CntOne;
        else if (!aw_hs && b_hs) w_out_d = w_out_q - CntOne;
        if (ar_hs && !r_last_hs)      r_out_d = r_out_q + CntOne;
        else if (!ar_hs && r_last_hs) r_out_d = r_out_q - CntOne;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_out_q       <= '0;
            r_out_q       <= '0;
            aw_lock_q     <= 1'b0;
            ar_lock_q     <= 1'b0;
            aw_lock_tgt_q <= '0;
            ar_lock_tgt_q <= '0;
            last_aw_tgt_q <= '0;
            last_ar_tgt_q <= '0;
        end else begin
            w_out_q <= w_out_d;
            r_out_q <= r_out_d;
            if (aw_hs) begin
                aw_lock_q     <= 1'b0;
                last_aw_tgt_q <= aw_tgt;
            end else if (aw_go) begin
                aw_lock_q     <= 1'b1;
                aw_lock_tgt_q <= aw_tgt;
            end
            if (ar_hs) begin
                ar_lock_q     <= 1'b0;
                last_ar_tgt_q <= ar_tgt;
            end else if (ar_go) begin
                ar_lock_q     <= 1'b1;
                ar_lock_tgt_q <= ar_tgt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_wr_ptr_q <= '0;
            w_rd_ptr_q <= '0;
            w_cnt_q    <= '0;
            for (int unsigned i = 0; i < MaxTrans; i++) w_fifo_q[i] <= '0;
        end else begin
            if (aw_hs) begin
                w_fifo_q[w_wr_ptr_q] <= aw_tgt;
                w_wr_ptr_q           <= ptr_inc(w_wr_ptr_q);
            end
            if (w_last_hs) w_rd_ptr_q <= ptr_inc(w_rd_ptr_q);
            if (aw_hs && !w_last_hs)      w_cnt_q <= w_cnt_q + CntOne;
            else if (!aw_hs && w_last_hs) w_cnt_q <= w_cnt_q - CntOne;
        end
    end

    axi_slv_port_router_err_slv u_err_slv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (err_req),
        .resp_o (err_resp)
    );

endmodule

// File: tb/tb_axi_slv_port_router.sv
// Directed bench for axi_slv_port_router: routing, ordering stalls, error responder, reset.
module tb_axi_slv_port_router;
    import axi_slv_port_router_pkg::*;

    logic       clk;
    logic       rst;
    req_t       slv_req;
    resp_t      slv_resp;
    req_t       mst_reqs [4];
    resp_t      mst_resps [4];
    rule_t      addr_map [4];
    logic       en_def;
    logic [1:0] def_port;

    int total;
    int bad;

    axi_slv_port_router dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .slv_req_i             (slv_req),
        .slv_resp_o            (slv_resp),
        .mst_reqs_o            (mst_reqs),
        .mst_resps_i           (mst_resps),
        .addr_map_i            (addr_map),
        .en_default_mst_port_i (en_def),
        .default_mst_port_i    (def_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_fwd();
        logic a;
        a = 1'b0;
        for (int i = 0; i < 4; i++)
            a = a | mst_reqs[i].aw_valid | mst_reqs[i].w_valid | mst_reqs[i].ar_valid;
        return a;
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        slv_req  = '0;
        en_def   = 1'b0;
        def_port = 2'd0;
        for (int i = 0; i < 4; i++) begin
            mst_resps[i]          = '0;
            mst_resps[i].aw_ready = 1'b1;
            mst_resps[i].w_ready  = 1'b1;
            mst_resps[i].ar_ready = 1'b1;
        end
        addr_map[0] = '{idx: 8'd0, start_addr: 32'h0000, end_addr: 32'h1000};
        addr_map[1] = '{idx: 8'd1, start_addr: 32'h1000, end_addr: 32'h2000};
        addr_map[2] = '{idx: 8'd2, start_addr: 32'h3000, end_addr: 32'h4000};
        addr_map[3] = '{idx: 8'd3, start_addr: 32'h3800, end_addr: 32'h3900};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_aw_ready", slv_resp.aw_ready, 0);
        chk("rst_w_ready", slv_resp.w_ready, 0);
        chk("rst_b_valid", slv_resp.b_valid, 0);
        chk("rst_r_valid", slv_resp.r_valid, 0);
        chk("rst_fwd", any_fwd(), 0);

        // Mapped write to mst 1, zero-latency AW.
        step();
        slv_req.aw.addr  = 32'h1800;
        slv_req.aw.id    = 4'd3;
        slv_req.aw.len   = 8'd0;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("aw1_mst1_valid", mst_reqs[1].aw_valid, 1);
        chk("aw1_mst0_valid", mst_reqs[0].aw_valid, 0);
        chk("aw1_ready", slv_resp.aw_ready, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data   = 64'hAB;
        slv_req.w.strb   = '1;
        slv_req.w.last   = 1'b1;
        slv_req.w_valid  = 1'b1;
        #1;
        chk("w1_mst1_valid", mst_reqs[1].w_valid, 1);
        chk("w1_mst1_data", mst_reqs[1].w.data, 64'hAB);
        chk("w1_ready", slv_resp.w_ready, 1);
        step();
        slv_req.w_valid        = 1'b0;
        mst_resps[1].b_valid   = 1'b1;
        mst_resps[1].b         = '{id: 4'd3, resp: RESP_OKAY};
        slv_req.b_ready        = 1'b1;
        #1;
        chk("b1_valid", slv_resp.b_valid, 1);
        chk("b1_id", slv_resp.b.id, 3);
        chk("b1_resp", slv_resp.b.resp, RESP_OKAY);
        chk("b1_mst1_ready", mst_reqs[1].b_ready, 1);
        step();
        mst_resps[1].b_valid = 1'b0;

        // Write outstanding to mst 0 blocks an AW to mst 1 until its B completes.
        slv_req.aw.addr  = 32'h0100;
        slv_req.aw.id    = 4'd1;
        slv_req.aw_valid = 1'b1;
        step();
        slv_req.aw.addr = 32'h1800;
        slv_req.aw.id   = 4'd2;
        slv_req.w.last  = 1'b1;
        slv_req.w_valid = 1'b1;
        #1;
        chk("ord_stall_ready", slv_resp.aw_ready, 0);
        chk("ord_stall_mst1", mst_reqs[1].aw_valid, 0);
        chk("ord_w_mst0", mst_reqs[0].w_valid, 1);
        step();
        slv_req.w_valid      = 1'b0;
        mst_resps[0].b_valid = 1'b1;
        mst_resps[0].b       = '{id: 4'd1, resp: RESP_OKAY};
        #1;
        chk("ord_stall_bcycle", slv_resp.aw_ready, 0);
        chk("ord_b_valid", slv_resp.b_valid, 1);
        step();
        mst_resps[0].b_valid = 1'b0;
        #1;
        chk("ord_release_ready", slv_resp.aw_ready, 1);
        chk("ord_release_mst1", mst_reqs[1].aw_valid, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        step();
        slv_req.w_valid      = 1'b0;
        mst_resps[1].b_valid = 1'b1;
        mst_resps[1].b       = '{id: 4'd2, resp: RESP_OKAY};
        step();
        mst_resps[1].b_valid = 1'b0;

        // Overlapping rules: the higher-index rule wins.
        slv_req.ar.addr  = 32'h3880;
        slv_req.ar.id    = 4'd4;
        slv_req.ar.len   = 8'd0;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("hi_mst3", mst_reqs[3].ar_valid, 1);
        chk("hi_mst2", mst_reqs[2].ar_valid, 0);
        step();
        slv_req.ar_valid     = 1'b0;
        mst_resps[3].r_valid = 1'b1;
        mst_resps[3].r       = '{id: 4'd4, data: 64'h55, resp: RESP_OKAY, last: 1'b1};
        slv_req.r_ready      = 1'b1;
        #1;
        chk("hi_r_data", slv_resp.r.data, 64'h55);
        step();
        mst_resps[3].r_valid = 1'b0;

        // Unmapped read: 4 DECERR beats from the error responder, with backpressure.
        slv_req.ar.addr  = 32'h9000;
        slv_req.ar.id    = 4'd5;
        slv_req.ar.len   = 8'd3;
        slv_req.ar_valid = 1'b1;
        slv_req.r_ready  = 1'b0;
        #1;
        chk("err_ar_fwd", any_fwd(), 0);
        chk("err_ar_ready", slv_resp.ar_ready, 1);
        step();
        slv_req.ar_valid = 1'b0;
        #1;
        chk("err_r_first", slv_resp.r_valid, 1);
        step();
        chk("err_r_hold", slv_resp.r_valid, 1);
        chk("err_r_hold_last", slv_resp.r.last, 0);
        slv_req.r_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("err_r_valid", slv_resp.r_valid, 1);
            chk("err_r_id", slv_resp.r.id, 5);
            chk("err_r_resp", slv_resp.r.resp, RESP_DECERR);
            chk("err_r_data", slv_resp.r.data, 0);
            chk("err_r_last", slv_resp.r.last, (i == 3) ? 1 : 0);
            step();
        end
        chk("err_r_done", slv_resp.r_valid, 0);

        // Same address with the default port enabled goes to mst 0.
        en_def           = 1'b1;
        def_port         = 2'd0;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("def_mst0", mst_reqs[0].ar_valid, 1);
        step();
        slv_req.ar_valid     = 1'b0;
        en_def               = 1'b0;
        mst_resps[0].r_valid = 1'b1;
        mst_resps[0].r       = '{id: 4'd5, data: 64'h0, resp: RESP_OKAY, last: 1'b1};
        step();
        mst_resps[0].r_valid = 1'b0;

        // MaxTrans reads outstanding: the ninth stalls until one R.last returns.
        slv_req.ar.addr  = 32'h0100;
        slv_req.ar.id    = 4'd7;
        slv_req.ar.len   = 8'd0;
        slv_req.ar_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mt_stall", slv_resp.ar_ready, 0);
        chk("mt_stall_mst0", mst_reqs[0].ar_valid, 0);
        mst_resps[0].r_valid = 1'b1;
        #1;
        chk("mt_stall_rcycle", slv_resp.ar_ready, 0);
        step();
        mst_resps[0].r_valid = 1'b0;
        #1;
        chk("mt_accept", slv_resp.ar_ready, 1);
        step();
        slv_req.ar_valid     = 1'b0;
        mst_resps[0].r_valid = 1'b1;
        repeat (8) step();
        mst_resps[0].r_valid = 1'b0;

        // Unmapped write: 3 beats sunk, DECERR one cycle after last, held under backpressure.
        slv_req.aw.addr  = 32'h9000;
        slv_req.aw.id    = 4'd6;
        slv_req.aw.len   = 8'd2;
        slv_req.aw_valid = 1'b1;
        slv_req.b_ready  = 1'b0;
        #1;
        chk("ew_aw_fwd", any_fwd(), 0);
        chk("ew_aw_ready", slv_resp.aw_ready, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_req.w.last = (i == 2);
            #1;
            chk("ew_w_ready", slv_resp.w_ready, 1);
            chk("ew_w_fwd", any_fwd(), 0);
            chk("ew_b_early", slv_resp.b_valid, 0);
            step();
        end
        slv_req.w_valid = 1'b0;
        #1;
        chk("ew_b_valid", slv_resp.b_valid, 1);
        chk("ew_b_id", slv_resp.b.id, 6);
        chk("ew_b_resp", slv_resp.b.resp, RESP_DECERR);
        step();
        chk("ew_b_hold", slv_resp.b_valid, 1);
        slv_req.b_ready = 1'b1;
        step();
        chk("ew_b_done", slv_resp.b_valid, 0);

        // Reset in the middle of a write burst drops the outstanding state.
        slv_req.aw.addr  = 32'h0100;
        slv_req.aw.id    = 4'd1;
        slv_req.aw.len   = 8'd3;
        slv_req.aw_valid = 1'b1;
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w.last   = 1'b0;
        slv_req.w_valid  = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst2_fwd", any_fwd(), 0);
        chk("rst2_w_ready", slv_resp.w_ready, 0);
        chk("rst2_b_valid", slv_resp.b_valid, 0);
        chk("rst2_r_valid", slv_resp.r_valid, 0);
        slv_req.w_valid  = 1'b0;
        slv_req.aw.addr  = 32'h1800;
        slv_req.aw.id    = 4'd2;
        slv_req.aw.len   = 8'd0;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("rst2_aw_ready", slv_resp.aw_ready, 1);
        chk("rst2_mst1", mst_reqs[1].aw_valid, 1);
        step();
        slv_req.aw_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
